// File: rtl/bus_pkg.sv
// Shared definitions for the common-bus arbiter: default sizes, helper, state type, source codes.
package bus_pkg;

  localparam int N_SRC_DEF = 7;
  localparam int SEL_W_DEF = 3;
  localparam int CNT_W_DEF = 8;

  // Ceiling log2, never below 1 so derived widths stay legal for tiny configurations.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Select codes of the basic computer's bus sources (0 = nobody drives the bus).
  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_AR   = 3'd1;
  localparam logic [2:0] SEL_PC   = 3'd2;
  localparam logic [2:0] SEL_DR   = 3'd3;
  localparam logic [2:0] SEL_AC   = 3'd4;
  localparam logic [2:0] SEL_IR   = 3'd5;
  localparam logic [2:0] SEL_TR   = 3'd6;
  localparam logic [2:0] SEL_MEM  = 3'd7;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: fixed priority (highest index) or round-robin
// starting just above ptr, built as a masked double-priority pick.
module rr_pick #(
  parameter int N_SRC = 7,
  parameter int PTR_W = 3
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             rr_en_i,
  output logic [PTR_W-1:0] win_o,
  output logic             valid_o,
  output logic             multi_o
);

  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] masked;
  logic [PTR_W-1:0] hi_win;
  logic [PTR_W-1:0] lo_req_win;
  logic [PTR_W-1:0] lo_mask_win;

  // Priority encoders: highest set bit, lowest set bit, lowest set bit above ptr.
  always_comb begin
    mask        = '0;
    hi_win      = '0;
    lo_req_win  = '0;
    lo_mask_win = '0;
    for (int i = 0; i < N_SRC; i++) begin
      mask[i] = (PTR_W'(i) > ptr_i);
    end
    masked = req_i & mask;
    for (int i = 0; i < N_SRC; i++) begin
      if (req_i[i]) hi_win = PTR_W'(i);
    end
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_i[i])  lo_req_win  = PTR_W'(i);
      if (masked[i]) lo_mask_win = PTR_W'(i);
    end
    if (!rr_en_i)      win_o = hi_win;
    else if (|masked)  win_o = lo_mask_win;
    else               win_o = lo_req_win;   // nothing above ptr: wrap to the bottom
    valid_o = |req_i;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi_o = |(req_i & (req_i - 1'b1));
  end

endmodule

// File: rtl/bus_arbiter.sv
// Registered common-bus arbiter: select code + one-hot grant, lockable grants,
// fixed/round-robin modes and sticky conflict flag with saturating counter.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req_i,
  input  logic             lock_i,
  input  logic             rr_en_i,
  input  logic             clr_err_i,
  output logic [SEL_W-1:0] sel_o,
  output logic [N_SRC-1:0] gnt_o,
  output logic             busy_o,
  output logic             conflict_o,
  output logic [CNT_W-1:0] conflict_cnt_o
);

  localparam int PTR_W = clog2(N_SRC);

  // Every source code 1..N_SRC must be representable on sel.
  if ((2 ** SEL_W) <= N_SRC) begin : g_bad_sel_w
    $error("bus_arbiter: SEL_W too narrow for N_SRC");
  end

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_SRC-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PTR_W-1:0] win;
  logic             any_req;
  logic             multi_req;
  logic             hold;

  rr_pick #(
    .N_SRC (N_SRC),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .rr_en_i (rr_en_i),
    .win_o   (win),
    .valid_o (any_req),
    .multi_o (multi_req)
  );

  // A locked grantee that keeps requesting freezes the arbiter for this edge.
  assign hold = (state_q == GRANT) && lock_i && |(req_i & gnt_q);

  // State and output registers; reset acts immediately, mid-transfer included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      ptr_q      <= PTR_W'(N_SRC - 1);
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      ptr_q      <= ptr_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next state: hold keeps GRANT, otherwise any request grants and none idles.
  always_comb begin
    state_d = state_q;
    if (!hold) state_d = any_req ? GRANT : IDLE;
  end

  // Next grant/select/pointer and conflict accounting.
  always_comb begin
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    ptr_d      = ptr_q;
    conflict_d = clr_err_i ? 1'b0 : conflict_q;
    cnt_d      = clr_err_i ? '0   : cnt_q;
    if (!hold) begin
      if (any_req) begin
        gnt_d  = {{(N_SRC-1){1'b0}}, 1'b1} << win;
        sel_d  = SEL_W'(win) + SEL_W'(1);
        busy_d = 1'b1;
        ptr_d  = win;
      end else begin
        gnt_d  = '0;
        sel_d  = '0;
        busy_d = 1'b0;
      end
      // Counting after the clear makes a same-edge conflict land on exactly 1.
      if (multi_req) begin
        conflict_d = 1'b1;
        if (cnt_d != {CNT_W{1'b1}}) cnt_d = cnt_d + CNT_W'(1);
      end
    end
  end

  assign sel_o          = sel_q;
  assign gnt_o          = gnt_q;
  assign busy_o         = busy_q;
  assign conflict_o     = conflict_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic
// against a behavioural model (granted index, rotation pointer, counters).
module tb_bus_arbiter;

  localparam int N = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         lock = 1'b0;
  logic         rr_en = 1'b0;
  logic         clr_err = 1'b0;

  logic [2:0]   sel, sel2;
  logic [N-1:0] gnt, gnt2;
  logic         busy, busy2, conf, conf2;
  logic [7:0]   cnt;
  logic [1:0]   cnt2;

  int checks = 0;
  int errors = 0;

  // Reference model state: granted source index (-1 = none), rotation pointer, counters.
  int m_g, m_ptr, m_cnt8, m_cnt2;
  bit m_conf;

  always #5 clk = ~clk;

  bus_arbiter #(.N_SRC(7), .SEL_W(3), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .lock_i(lock), .rr_en_i(rr_en),
    .clr_err_i(clr_err), .sel_o(sel), .gnt_o(gnt), .busy_o(busy),
    .conflict_o(conf), .conflict_cnt_o(cnt)
  );

  bus_arbiter #(.N_SRC(7), .SEL_W(3), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .req_i(req), .lock_i(lock), .rr_en_i(rr_en),
    .clr_err_i(clr_err), .sel_o(sel2), .gnt_o(gnt2), .busy_o(busy2),
    .conflict_o(conf2), .conflict_cnt_o(cnt2)
  );

  function automatic void m_reset();
    m_g = -1; m_ptr = N - 1; m_cnt8 = 0; m_cnt2 = 0; m_conf = 0;
  endfunction

  // One clock edge of the arbitration rules, evaluated on the current inputs.
  function automatic void m_step();
    int n;
    bit hold;
    n = $countones(req);
    hold = (m_g >= 0) && lock && req[m_g];
    if (clr_err) begin m_conf = 0; m_cnt8 = 0; m_cnt2 = 0; end
    if (!hold) begin
      if (n >= 2) begin
        m_conf = 1;
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (n == 0) m_g = -1;
      else if (!rr_en) begin
        for (int i = 0; i < N; i++) if (req[i]) m_g = i;
      end else begin
        for (int k = N; k >= 1; k--) if (req[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
      end
      if (n != 0) m_ptr = m_g;
    end
  endfunction

  function automatic int exp_sel();
    return m_g + 1;
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] one;
    one = 1;
    return (m_g < 0) ? '0 : (one << m_g);
  endfunction

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic do_reset();
    req = '0; lock = 0; clr_err = 0;
    rst_n = 0;
    #2;
    m_reset();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    checks++; if (gnt !== 7'd0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000000", gnt); end
    checks++; if (busy !== 1'b0 || conf !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%b conflict=%b expected 0 0", busy, conf); end
    checks++; if (cnt !== 8'd0 || cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt, cnt2); end
    m_reset();
    rst_n = 1;
    tick();
    checks++; if (sel !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle_edge: got sel=%0d busy=%b expected 0 0", sel, busy); end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    rr_en = 0; req = 7'b0010010;
    tick();
    checks++; if (sel !== 3'd5) begin errors++; $display("FAIL fixed_sel: got %0d expected 5", sel); end
    checks++; if (gnt !== 7'b0010000) begin errors++; $display("FAIL fixed_gnt: got %b expected 0010000", gnt); end
    checks++; if (busy !== 1'b1 || conf !== 1'b1) begin errors++; $display("FAIL fixed_flags: got busy=%b conflict=%b expected 1 1", busy, conf); end
    checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL fixed_cnt: got %0d expected 1", cnt); end
  endtask

  task automatic test_round_robin();
    int seq[8] = '{1, 2, 3, 4, 5, 6, 7, 1};
    do_reset();
    rr_en = 1; req = 7'b1111111;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (sel !== 3'(seq[i])) begin errors++; $display("FAIL rr_sel[%0d]: got %0d expected %0d", i, sel, seq[i]); end
    end
    checks++; if (cnt !== 8'd8) begin errors++; $display("FAIL rr_cnt: got %0d expected 8", cnt); end
    checks++; if (cnt2 !== 2'd3) begin errors++; $display("FAIL rr_cnt_sat: got %0d expected 3", cnt2); end
  endtask

  task automatic test_idle();
    req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (sel !== 3'd0 || busy !== 1'b0 || gnt !== 7'd0) begin errors++; $display("FAIL idle[%0d]: got sel=%0d busy=%b expected 0 0", i, sel, busy); end
      checks++; if (cnt !== 8'd8) begin errors++; $display("FAIL idle_cnt[%0d]: got %0d expected 8", i, cnt); end
    end
  endtask

  task automatic test_lock();
    do_reset();
    rr_en = 0; req = 7'b0000100;
    tick();
    checks++; if (sel !== 3'd3) begin errors++; $display("FAIL lock_first: got %0d expected 3", sel); end
    lock = 1; req = 7'b1000100;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (sel !== 3'd3 || gnt !== 7'b0000100) begin errors++; $display("FAIL lock_hold[%0d]: got sel=%0d expected 3", i, sel); end
      checks++; if (cnt !== 8'd0 || conf !== 1'b0) begin errors++; $display("FAIL lock_cnt[%0d]: got %0d expected 0", i, cnt); end
    end
    req = 7'b1000000;
    tick();
    checks++; if (sel !== 3'd7 || busy !== 1'b1) begin errors++; $display("FAIL lock_release: got sel=%0d busy=%b expected 7 1", sel, busy); end
    lock = 0;
  endtask

  task automatic test_saturation_clear();
    do_reset();
    rr_en = 1; req = 7'b1111111;
    repeat (5) tick();
    checks++; if (cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt2: got %0d expected 3", cnt2); end
    checks++; if (cnt !== 8'd5) begin errors++; $display("FAIL sat_cnt8: got %0d expected 5", cnt); end
    clr_err = 1; req = 7'b0000011;
    tick();
    checks++; if (conf !== 1'b1 || cnt !== 8'd1 || cnt2 !== 2'd1) begin errors++; $display("FAIL clr_conflict: got conflict=%b cnt=%0d/%0d expected 1 1/1", conf, cnt, cnt2); end
    req = '0;
    tick();
    checks++; if (conf !== 1'b0 || cnt !== 8'd0 || cnt2 !== 2'd0) begin errors++; $display("FAIL clr_idle: got conflict=%b cnt=%0d/%0d expected 0 0/0", conf, cnt, cnt2); end
    checks++; if (sel !== 3'd0) begin errors++; $display("FAIL clr_idle_sel: got %0d expected 0", sel); end
    clr_err = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    rr_en = 0; req = 7'b0100000;
    tick();
    lock = 1;
    tick(); tick();
    checks++; if (sel !== 3'd6) begin errors++; $display("FAIL async_pre: got %0d expected 6", sel); end
    #2 rst_n = 0;
    #1;
    checks++; if (sel !== 3'd0 || gnt !== 7'd0 || busy !== 1'b0) begin errors++; $display("FAIL async_clear: got sel=%0d gnt=%b busy=%b expected 0 0 0", sel, gnt, busy); end
    m_reset();
    rst_n = 1;
    lock = 0; rr_en = 1; req = 7'b1111111;
    tick();
    checks++; if (sel !== 3'd1) begin errors++; $display("FAIL async_after: got %0d expected 1", sel); end
  endtask

  task automatic test_cnt8_saturation();
    do_reset();
    rr_en = 0; req = 7'b1100000;
    repeat (260) tick();
    checks++; if (cnt !== 8'd255) begin errors++; $display("FAIL cnt8_sat: got %0d expected 255", cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req     = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom);
      if ($urandom_range(0, 3) == 0) req = req & 7'($urandom);
      lock    = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) rr_en = ~rr_en;
      clr_err = ($urandom_range(0, 15) == 0);
      tick();
      checks++; if (sel !== 3'(exp_sel()) || gnt !== exp_gnt()) begin errors++; $display("FAIL rand_grant[%0d]: got sel=%0d gnt=%b expected sel=%0d gnt=%b", i, sel, gnt, exp_sel(), exp_gnt()); end
      checks++; if (busy !== (m_g >= 0)) begin errors++; $display("FAIL rand_busy[%0d]: got %b expected %b", i, busy, (m_g >= 0)); end
      checks++; if (conf !== m_conf || cnt !== 8'(m_cnt8) || cnt2 !== 2'(m_cnt2)) begin errors++; $display("FAIL rand_conflict[%0d]: got %b %0d/%0d expected %b %0d/%0d", i, conf, cnt, cnt2, m_conf, m_cnt8, m_cnt2); end
    end
    clr_err = 0; lock = 0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_idle();
    test_lock();
    test_saturation_clear();
    test_async_reset();
    test_cnt8_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
